ula_sched: RTL and testbench

Round-robin scheduler that shares one `ula` instance among `NREQ` requesters. It accepts one operation at a time over a valid/ready handshake, drives the ALU operand and opcode inputs, and waits out the ALU's one-cycle registered latency. It then returns the result, a zero flag and the winner's response strobe over a valid/ready response handshake. It sits between the requesting blocks and the single ALU datapath.

---
 rtl/ula_pkg.sv | 5 +
 rtl/ula_rr_arbiter.sv | 27 ++
 rtl/ula_sched.sv | 77 +++++++
 tb/tb_ula_sched.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: shared opcode and scheduler state types for the ula scheduler slice
package ula_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
endpackage

// File: rtl/ula_rr_arbiter.sv
// ula_rr_arbiter: combinational round-robin pick of the first set request at or above ptr
module ula_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);
  int j;
  assign any = |req;
  // Scan from the farthest offset down so the nearest request to ptr wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (|(req & (NREQ'(1) << j))) begin
        gnt = NREQ'(1) << j;
        idx = PW'(j);
      end
    end
  end
endmodule

// File: rtl/ula_sched.sv
// ula_sched: round-robin sharing of one registered-latency ALU among NREQ requesters
module ula_sched
  import ula_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic [1:0]            alu_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_result,
  output logic                  busy
);
  localparam int PW = $clog2(NREQ);
  state_t state, nxt;
  logic [PW-1:0] ptr, g, win;
  logic [NREQ-1:0] gnt;
  logic any, accept, done;
  ula_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(win),
    .any(any)
  );
  // rst_n gates the grant so req_ready reads 0 while reset is held
  assign accept = rst_n && state == IDLE && any;
  assign done = state == RESP && |(rsp_ready & (NREQ'(1) << g));
  assign req_ready = accept ? gnt : '0;
  assign rsp_valid = state == RESP ? NREQ'(1) << g : '0;
  assign busy = state != IDLE;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (any ? EXEC : IDLE) :
          state == EXEC ? CAPT :
          state == CAPT ? RESP :
          (done ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      g <= '0;
      alu_op <= '0;
      alu_a <= '0;
      alu_b <= '0;
      rsp_result <= '0;
      rsp_zero <= 1'b0;
    end else begin
      if (accept) begin
        g <= win;
        alu_op <= req_op[2*win +: 2];
        alu_a <= req_a[WIDTH*win +: WIDTH];
        alu_b <= req_b[WIDTH*win +: WIDTH];
      end
      if (state == CAPT) begin
        rsp_result <= alu_result;
        rsp_zero <= alu_result == '0;
      end
      if (done) ptr <= g == PW'(NREQ - 1) ? '0 : g + 1'b1;
    end
  end
endmodule

// File: tb/tb_ula_sched.sv
// tb_ula_sched: directed self-checking bench for ula_sched with a registered ALU model
module tb_ula_sched;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_a, req_b;
  logic [W-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic rsp_zero, busy;
  logic [1:0] alu_op;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    alu_result <= alu_op == 2'b00 ? alu_a + alu_b :
                  alu_op == 2'b01 ? alu_a - alu_b :
                  alu_op == 2'b10 ? alu_a & alu_b : alu_a | alu_b;

  ula_sched #(.NREQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .busy(busy)
  );

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[2*i +: 2] = op;
    req_a[W*i +: W] = a;
    req_b[W*i +: W] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic run_op(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [1:0] eop, output logic [W-1:0] ea, output logic [W-1:0] eb,
                        output logic [W-1:0] res, output logic z, output logic [N-1:0] vld);
    int n = 0;
    lat = -1; eop = 'x; ea = 'x; eb = 'x; res = 'x; z = 1'bx; vld = '0;
    set_req(i, op, a, b);
    #1;
    while (!req_ready[i] && n < 20) begin @(negedge clk); #1; n++; end
    if (!req_ready[i]) begin req_valid[i] = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
    eop = alu_op; ea = alu_a; eb = alu_b; lat = 1;
    while (rsp_valid == '0 && lat < 10) begin @(negedge clk); lat++; end
    res = rsp_result; z = rsp_zero; vld = rsp_valid;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({req_ready, rsp_valid, busy} !== '0) begin errors++; $display("FAIL reset_ctrl: got %b want 0", {req_ready, rsp_valid, busy}); end
    checks++; if ({rsp_result, rsp_zero} !== '0) begin errors++; $display("FAIL reset_rsp: got %h/%b want 0/0", rsp_result, rsp_zero); end
    checks++; if ({alu_op, alu_a, alu_b} !== '0) begin errors++; $display("FAIL reset_alu: got %h %h %h want 0", alu_op, alu_a, alu_b); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    int lat; logic [1:0] eop; logic [W-1:0] ea, eb, res; logic z; logic [N-1:0] vld;
    run_op(0, 2'b00, 5, 7, lat, eop, ea, eb, res, z, vld);
    checks++; if (lat !== 3) begin errors++; $display("FAIL single_latency: got %0d want 3", lat); end
    checks++; if ({eop, ea, eb} !== {2'b00, 32'd5, 32'd7}) begin errors++; $display("FAIL single_exec: got %h %0d %0d want 0 5 7", eop, ea, eb); end
    checks++; if (vld !== 4'b0001) begin errors++; $display("FAIL single_vld: got %b want 0001", vld); end
    checks++; if ({res, z} !== {32'd12, 1'b0}) begin errors++; $display("FAIL single_result: got %0d z=%b want 12 z=0", res, z); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_done: busy got %b want 0", busy); end
  endtask

  task automatic test_zero_wrap();
    int lat; logic [1:0] eop; logic [W-1:0] ea, eb, res; logic z; logic [N-1:0] vld;
    logic [1:0] ops[3] = '{2'b01, 2'b00, 2'b01};
    logic [W-1:0] as[3] = '{32'd3, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] bs[3] = '{32'd3, 32'd1, 32'd1};
    logic [W-1:0] rs[3] = '{32'd0, 32'd0, 32'hFFFF_FFFF};
    logic zs[3] = '{1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 3; t++) begin
      run_op(t + 1, ops[t], as[t], bs[t], lat, eop, ea, eb, res, z, vld);
      checks++; if ({res, z} !== {rs[t], zs[t]}) begin errors++; $display("FAIL zero_wrap_%0d: got %h z=%b want %h z=%b", t, res, z, rs[t], zs[t]); end
      checks++; if (vld !== N'(1) << (t + 1)) begin errors++; $display("FAIL zero_wrap_vld_%0d: got %b want %b", t, vld, N'(1) << (t + 1)); end
    end
  endtask

  task automatic test_round_robin();
    int n, m; logic bad; logic [N-1:0] g;
    for (int i = 0; i < N; i++) set_req(i, 2'b00, W'(i * 10), 1);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      #1;
      while (req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
      g = req_ready;
      checks++; if (g !== N'(1) << (k % N)) begin errors++; $display("FAIL rr_grant_%0d: got %b want %b", k, g, N'(1) << (k % N)); end
      bad = 1'b0; m = 0;
      do begin @(negedge clk); m++; if (req_ready != '0) bad = 1'b1; end while (rsp_valid == '0 && m < 10);
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rr_no_regrant_%0d: got %b want 0", k, bad); end
      checks++; if (rsp_valid !== g) begin errors++; $display("FAIL rr_rsp_%0d: got %b want %b", k, rsp_valid, g); end
      checks++; if (rsp_result !== W'((k % N) * 10 + 1)) begin errors++; $display("FAIL rr_result_%0d: got %0d want %0d", k, rsp_result, (k % N) * 10 + 1); end
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_logic();
    int lat; logic [1:0] eop; logic [W-1:0] ea, eb, res; logic z; logic [N-1:0] vld;
    run_op(2, 2'b10, 32'hF0, 32'h3C, lat, eop, ea, eb, res, z, vld);
    checks++; if ({vld, res, z} !== {4'b0100, 32'h30, 1'b0}) begin errors++; $display("FAIL logic_and: got %b %h z=%b want 0100 30 z=0", vld, res, z); end
    run_op(0, 2'b11, 32'hF0, 32'h0F, lat, eop, ea, eb, res, z, vld);
    checks++; if ({vld, res, z} !== {4'b0001, 32'hFF, 1'b0}) begin errors++; $display("FAIL logic_or: got %b %h z=%b want 0001 ff z=0", vld, res, z); end
  endtask

  task automatic test_backpressure();
    int n = 0; int m = 0;
    rsp_ready = 4'b1101;
    set_req(1, 2'b00, 100, 23);
    #1;
    while (!req_ready[1] && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    set_req(0, 2'b00, 1, 1);
    while (rsp_valid == '0 && m < 10) begin @(negedge clk); m++; end
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if ({rsp_valid, rsp_result, busy, req_ready} !== {4'b0010, 32'd123, 1'b1, 4'b0000}) begin
        errors++; $display("FAIL bp_hold_%0d: got vld=%b res=%0d busy=%b rdy=%b want 0010 123 1 0000", c, rsp_valid, rsp_result, busy, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    #1;
    checks++; if ({busy, rsp_valid, req_ready} !== {1'b0, 4'b0000, 4'b0001}) begin errors++; $display("FAIL bp_release: got busy=%b vld=%b rdy=%b want 0 0000 0001", busy, rsp_valid, req_ready); end
    req_valid[0] = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_drop_ready: got %b want 0000", req_ready); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_drop_nogrant: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_exec();
    int n = 0; int m = 0;
    set_req(3, 2'b01, 9, 4);
    #1;
    while (!req_ready[3] && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    checks++; if ({busy, alu_a} !== {1'b1, 32'd9}) begin errors++; $display("FAIL rst_exec_pre: got busy=%b a=%0d want 1 9", busy, alu_a); end
    rst_n = 1'b0;
    #1;
    checks++; if ({req_ready, rsp_valid, rsp_result, rsp_zero, alu_op, alu_a, alu_b, busy} !== '0) begin
      errors++; $display("FAIL rst_exec_outputs: got rdy=%b vld=%b res=%h z=%b op=%h a=%h b=%h busy=%b want all 0", req_ready, rsp_valid, rsp_result, rsp_zero, alu_op, alu_a, alu_b, busy);
    end
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({rsp_valid, busy} !== '0) begin errors++; $display("FAIL rst_exec_stale_%0d: got vld=%b busy=%b want 0 0", c, rsp_valid, busy); end
    end
    for (int i = 0; i < N; i++) set_req(i, 2'b00, W'(i), 2);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_exec_ptr: got %b want 0001", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    while (rsp_valid == '0 && m < 10) begin @(negedge clk); m++; end
    checks++; if ({rsp_valid, rsp_result} !== {4'b0001, 32'd2}) begin errors++; $display("FAIL rst_exec_after: got %b %0d want 0001 2", rsp_valid, rsp_result); end
    @(negedge clk);
  endtask

  initial begin
    req_valid = '0;
    rsp_ready = '1;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_single();
    test_zero_wrap();
    test_round_robin();
    test_logic();
    test_backpressure();
    test_reset_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
